ps2_host_tx: RTL

PS/2 host-to-device transmitter. Sends one command byte to the keyboard, such as LED set 0xED, reset 0xFF or enable 0xF4, using the open-drain request-to-send sequence. It captures the device ACK bit and reports the result. It sits beside the PS/2 receiver on the same ps2_clk/ps2_data pins. The receiver must ignore traffic while busy=1.

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_host_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the receiver.
package ps2_pkg;

  // Keyboard command bytes and the device acknowledge response.
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Cycle counter must hold the 15 ms start window at 100 MHz.
  localparam int CNT_W     = 21;
  localparam int BIT_CNT_W = 4;

  // Result reported alongside done.
  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_START_TO = 2'd1,
    ERR_XFER_TO  = 2'd2,
    ERR_NACK     = 2'd3
  } ps2_err_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INHIBIT    = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_WAIT_FIRST = 3'd3,
    ST_SHIFT      = 3'd4,
    ST_ACK        = 3'd5,
    ST_WAIT_IDLE  = 3'd6,
    ST_FINISH     = 3'd7
  } ps2_tx_state_e;

  // Host frame payload: {odd parity, data}; data leaves LSB first.
  function automatic logic [8:0] ps2_frame(input logic [7:0] data);
    return {~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: two-flop synchronizer, FILTER_LEN-sample glitch
// filter, and falling-edge detect on the filtered level.
// FILTER_LEN must be at least 2. Filtered level idles high out of reset.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_hist;
  logic                  r_level;
  logic                  r_level_d;

  // Synchronize the pin, keep a sample history, and move the level only
  // when the whole history agrees.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync    <= '1;
      r_hist    <= '1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_pin};
      r_hist    <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
      if (&r_hist) begin
        r_level <= 1'b1;
      end else if (~|r_hist) begin
        r_level <= 1'b0;
      end
      r_level_d <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_level_d & ~r_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain request-to-send).
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   IDLE        | lines released, ready for a command byte
//   INHIBIT     | clock held low; data pulled low on the final cycle
//   RELEASE     | one cycle with both lines low, then clock released
//   WAIT_FIRST  | waiting for the device to start clocking
//   SHIFT       | presenting data bits and parity on device falling edges
//   ACK         | stop bit released, sampling the device ACK on fall 11
//   WAIT_IDLE   | waiting for the device to release both lines
//   FINISH      | one-cycle done pulse with the result code
//
// INHIBIT_CYCLES must comfortably exceed the filter latency (FILTER_LEN+3)
// so the falling edge caused by our own inhibit lands while the FSM is
// still in INHIBIT, where edges are not consumed.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [CNT_W-1:0] LP_INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_INH_PRE    = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] LP_START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
  localparam logic             LP_INH_ONE    = (INHIBIT_CYCLES == 1);

  ps2_tx_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [8:0]             r_shreg, w_shreg_nxt;
  ps2_err_e               r_err, w_err_nxt;
  logic                   r_clk_oe, w_clk_oe_nxt;
  logic                   r_data_oe, w_data_oe_nxt;
  logic                   r_done, w_done_nxt;
  logic [1:0]             r_err_code;

  logic w_clk_lvl, w_clk_fall;
  logic w_data_lvl;
  // Data edges are not needed on the transmit side.
  logic w_data_fall_unused;
  logic w_xfer_to;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .i_clk   (clk_100mhz),
    .i_rst_n (rst_n),
    .i_pin   (ps2_clk_in),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .i_clk   (clk_100mhz),
    .i_rst_n (rst_n),
    .i_pin   (ps2_data_in),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall_unused)
  );

  // Saturating cycle counter increment; never wraps.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_xfer_to = (r_cnt >= LP_XFER_LAST);

  // Next-state and next-output decode; line drives and done are registered
  // so the pins never glitch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_cnt_inc;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    w_err_nxt     = r_err;
    w_clk_oe_nxt  = 1'b0;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt     = '0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_state_nxt   = ST_INHIBIT;
          w_shreg_nxt   = ps2_frame(tx_data);
          w_bit_cnt_nxt = '0;
          w_err_nxt     = ERR_OK;
          w_clk_oe_nxt  = 1'b1;
          w_data_oe_nxt = LP_INH_ONE;
        end
      end

      ST_INHIBIT: begin
        w_clk_oe_nxt = 1'b1;
        if (r_cnt == LP_INH_LAST) begin
          w_state_nxt   = ST_RELEASE;
          w_data_oe_nxt = 1'b1;
        end else if (r_cnt == LP_INH_PRE) begin
          // Registered drive: raising it now puts the start bit on the
          // final inhibit cycle.
          w_data_oe_nxt = 1'b1;
        end
      end

      ST_RELEASE: begin
        w_data_oe_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = ST_WAIT_FIRST;
      end

      ST_WAIT_FIRST: begin
        if (w_clk_fall) begin
          w_data_oe_nxt = ~r_shreg[0];
          w_shreg_nxt   = {1'b0, r_shreg[8:1]};
          w_bit_cnt_nxt = BIT_CNT_W'(1);
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_SHIFT;
        end else if (r_cnt >= LP_START_LAST) begin
          w_err_nxt     = ERR_START_TO;
          w_data_oe_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = ST_FINISH;
        end
      end

      ST_SHIFT: begin
        if (w_clk_fall) begin
          w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          if (r_bit_cnt == BIT_CNT_W'(9)) begin
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = ST_ACK;
          end else begin
            w_data_oe_nxt = ~r_shreg[0];
            w_shreg_nxt   = {1'b0, r_shreg[8:1]};
          end
        end else if (w_xfer_to) begin
          w_err_nxt     = ERR_XFER_TO;
          w_data_oe_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = ST_FINISH;
        end
      end

      ST_ACK: begin
        if (w_clk_fall) begin
          w_err_nxt   = w_data_lvl ? ERR_NACK : ERR_OK;
          w_state_nxt = ST_WAIT_IDLE;
        end else if (w_xfer_to) begin
          w_err_nxt     = ERR_XFER_TO;
          w_data_oe_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = ST_FINISH;
        end
      end

      ST_WAIT_IDLE: begin
        if (w_clk_lvl && w_data_lvl) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_FINISH;
        end else if (w_xfer_to) begin
          w_err_nxt     = ERR_XFER_TO;
          w_data_oe_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = ST_FINISH;
        end
      end

      ST_FINISH: begin
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end

      default: begin
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_err      <= ERR_OK;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_err_code <= ERR_OK;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_err      <= w_err_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_err_code <= w_done_nxt ? w_err_nxt : ERR_OK;
    end
  end

  assign tx_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign err_code    = r_err_code;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule
